// File: rtl/odd_parity_tx_pkg.sv
// Shared state encoding and line-level constants for the odd-parity serial transmitter.
package odd_parity_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/odd_parity_tx_baud.sv
// Bit-period counter: counts CLKS_PER_BIT cycles per serial bit and flags the last one.
module odd_parity_tx_baud #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_end_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    assign bit_end      = (cnt_r == CNT_LAST);
    // Look-ahead lets the parent register pulses that line up with bit_end.
    assign bit_end_next = (cnt_s == CNT_LAST);

    // Next count: restart on clear or at every bit boundary.
    always_comb begin
        cnt_s = cnt_r;
        if (clear || bit_end) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/odd_parity_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, odd parity bit, stop bit.
// Optional macro ODD_PARITY_TX_INJECT_EN adds inject_err to invert a frame's parity bit.
module odd_parity_tx
    import odd_parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef ODD_PARITY_TX_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic              parity_r;
    logic              parity_s;
    logic              tx_r;
    logic              tx_s;
    logic              in_ready_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              handshake_s;
    logic              inject_s;
    logic              bit_end_s;
    logic              bit_end_next_s;

    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

`ifdef ODD_PARITY_TX_INJECT_EN
    assign inject_s = inject_err;
`else
    assign inject_s = 1'b0;
`endif

    assign handshake_s = in_valid && in_ready_r;

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign tx         = tx_r;
    assign frame_done = frame_done_r;

    odd_parity_tx_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_r == IDLE),
        .bit_end      (bit_end_s),
        .bit_end_next (bit_end_next_s)
    );

    // Frame sequencing, word capture and data shifting.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        idx_s    = idx_r;
        parity_s = parity_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_s  = START;
                    shreg_s  = in_data;
                    idx_s    = '0;
                    parity_s = odd_parity(in_data) ^ inject_s;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    idx_s   = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                        idx_s   = idx_r + IDX_ONE;
                        shreg_s = shreg_r >> 1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx can be registered.
    always_comb begin
        tx_s = LINE_IDLE;
        case (state_s)
            IDLE:    tx_s = LINE_IDLE;
            START:   tx_s = START_BIT;
            DATA:    tx_s = shreg_s[0];
            PARITY:  tx_s = parity_s;
            STOP:    tx_s = STOP_BIT;
            default: tx_s = LINE_IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame and drops a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            idx_r        <= '0;
            parity_r     <= 1'b0;
            tx_r         <= LINE_IDLE;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            idx_r        <= idx_s;
            parity_r     <= parity_s;
            tx_r         <= tx_s;
            in_ready_r   <= (state_s == IDLE);
            busy_r       <= (state_s != IDLE);
            frame_done_r <= (state_s == STOP) && bit_end_next_s;
        end
    end

endmodule

// File: tb/tb_odd_parity_tx.sv
// Self-checking bench for odd_parity_tx: vector table, random frames, reset and back-to-back cases.
module tb_odd_parity_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int LEN = (DW + 3) * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, inject_err;
    logic [DW-1:0] in_data;
    logic          in_ready, tx, busy, frame_done;

    logic          rst1, in_valid1, inject_err1;
    logic [DW-1:0] in_data1;
    logic          in_ready1, tx1, busy1, frame_done1;

    int total = 0;
    int bad   = 0;

    odd_parity_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
`ifdef ODD_PARITY_TX_INJECT_EN
        .inject_err (inject_err),
`endif
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    odd_parity_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
`ifdef ODD_PARITY_TX_INJECT_EN
        .inject_err (inject_err1),
`endif
        .in_ready   (in_ready1),
        .tx         (tx1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          exp_par;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: parity from a ones count, line level from the bit slot index.
    function automatic logic ref_parity(input logic [DW-1:0] d, input logic inj);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(d[i]);
        return (((ones % 2) == 0) ? 1'b1 : 1'b0) ^ inj;
    endfunction

    function automatic logic ref_tx(input logic [DW-1:0] d, input logic inj, input int cpb, input int k);
        int b;
        if (k < 1 || k > (DW + 3) * cpb) return 1'b1;
        b = (k - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (b == DW + 1) return ref_parity(d, inj);
        return 1'b1;
    endfunction

    // Starts a frame in the current (idle) cycle and checks every cycle through T+LEN+1.
    task automatic send_frame(input logic [DW-1:0] d, input logic inj, input string tag,
                              output logic obs_par);
        obs_par    = 1'bx;
        in_data    = d;
        in_valid   = 1'b1;
        inject_err = inj;
        chk({tag, " ready@T"}, in_ready, 1);
        chk({tag, " busy@T"}, busy, 0);
        for (int k = 1; k <= LEN; k++) begin
            @(posedge clk); #1;
            in_valid   = (k < LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data    = DW'($urandom);
            inject_err = 1'($urandom_range(0, 1));
            chk($sformatf("%s tx T+%0d", tag, k), tx, ref_tx(d, inj, CPB, k));
            chk($sformatf("%s done T+%0d", tag, k), frame_done, (k == LEN) ? 1 : 0);
            chk($sformatf("%s ready T+%0d", tag, k), in_ready, 0);
            chk($sformatf("%s busy T+%0d", tag, k), busy, 1);
            if (k == (DW + 1) * CPB + 1) obs_par = tx;
        end
        @(posedge clk); #1;
        inject_err = 1'b0;
        chk({tag, " tx idle end"}, tx, 1);
        chk({tag, " ready end"}, in_ready, 1);
        chk({tag, " busy end"}, busy, 0);
        chk({tag, " done end"}, frame_done, 0);
    endtask

    initial begin
        logic par;
        logic inj;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; inject_err = 1'b0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; inject_err1 = 1'b0;

        vt[0] = '{8'h00, 1'b1};
        vt[1] = '{8'h07, 1'b0};
        vt[2] = '{8'hFF, 1'b1};
        vt[3] = '{8'hA5, 1'b1};
        vt[4] = '{8'h3C, 1'b1};
        vt[5] = '{8'h80, 1'b0};
        vt[6] = '{8'h01, 1'b0};
        vt[7] = '{8'hFE, 1'b0};

        // Reset held with in_valid asserted must not start a frame.
        in_valid = 1'b1; in_data = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst tx c%0d", c), tx, 1);
            chk($sformatf("rst ready c%0d", c), in_ready, 1);
            chk($sformatf("rst busy c%0d", c), busy, 0);
            chk($sformatf("rst done c%0d", c), frame_done, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post-rst tx", tx, 1);
        chk("post-rst ready", in_ready, 1);

        // Table vectors sent back-to-back: each next word accepted at T+45.
        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].data, 1'b0, $sformatf("vec%0d", i), par);
            chk($sformatf("vec%0d parity", i), par, vt[i].exp_par);
        end

        // Reset at T+20 of a frame, then a handshake attempt while still in reset.
        in_data = 8'h55; in_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("abort tx T+%0d", k), tx, ref_tx(8'h55, 1'b0, CPB, k));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort tx", tx, 1);
        chk("abort ready", in_ready, 1);
        chk("abort busy", busy, 0);
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1;
        chk("rst-handshake tx", tx, 1);
        chk("rst-handshake ready", in_ready, 1);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("after abort tx", tx, 1);
        chk("after abort busy", busy, 0);
        send_frame(8'h01, 1'b0, "post-abort", par);
        chk("post-abort parity", par, 0);

        // Random frames with random idle gaps.
        for (int r = 0; r < 16; r++) begin
            logic [DW-1:0] d;
            int gap;
            d   = DW'($urandom);
`ifdef ODD_PARITY_TX_INJECT_EN
            inj = 1'($urandom_range(0, 1));
`else
            inj = 1'b0;
`endif
            send_frame(d, inj, $sformatf("rnd%0d", r), par);
            chk($sformatf("rnd%0d parity", r), par, ref_parity(d, inj));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d gap tx", r), tx, 1);
                chk($sformatf("rnd%0d gap ready", r), in_ready, 1);
            end
        end

`ifdef ODD_PARITY_TX_INJECT_EN
        send_frame(8'h00, 1'b1, "inject", par);
        chk("inject parity", par, 0);
`endif

        // Single-cycle bit period: 11-cycle frame, frame_done at T+11.
        @(posedge clk); #1;
        rst1 = 1'b0;
        @(posedge clk); #1;
        chk("cpb1 ready@T", in_ready1, 1);
        in_data1 = 8'h07; in_valid1 = 1'b1;
        for (int k = 1; k <= DW + 3; k++) begin
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            in_data1  = DW'($urandom);
            chk($sformatf("cpb1 tx T+%0d", k), tx1, ref_tx(8'h07, 1'b0, 1, k));
            chk($sformatf("cpb1 done T+%0d", k), frame_done1, (k == DW + 3) ? 1 : 0);
            chk($sformatf("cpb1 busy T+%0d", k), busy1, 1);
        end
        @(posedge clk); #1;
        chk("cpb1 ready end", in_ready1, 1);
        chk("cpb1 tx end", tx1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/odd_parity_tx.md
ODD_PARITY_TX -- requirements
Module: odd_parity_tx

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; SHALL be >= 1.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_W  parallel word to transmit.
REQ-006 in_valid  input  1  in_data is offered this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 tx  output  1  serial line; idle/mark = 1.
REQ-009 busy  output  1  frame in progress.
REQ-010 frame_done  output  1  one-cycle pulse on last cycle of stop bit.

Function
REQ-011 Handshake SHALL occur on a cycle T with in_valid=1 and in_ready=1; in_data is latched at T; in_valid without in_ready SHALL be ignored.
REQ-012 in_ready SHALL be 1 only in IDLE; busy SHALL equal NOT in_ready.
REQ-013 Parity bit SHALL be odd parity of the latched word: XNOR-reduction of all DATA_W bits (total ones across data+parity is odd).
REQ-014 States IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; each non-IDLE state holds for CLKS_PER_BIT cycles per bit via a bit-period counter reset on every bit boundary.
REQ-015 tx SHALL be 1 in IDLE, 0 in START, data bit LSB first in DATA, parity bit in PARITY, 1 in STOP.
REQ-016 Timing (defaults): START on T+1..T+4, bit0 T+5..T+8, bit7 T+33..T+36, parity T+37..T+40, stop T+41..T+44, IDLE with in_ready=1 at T+45; general frame length (DATA_W+3)*CLKS_PER_BIT cycles.
REQ-017 DATA state SHALL use a bit index counter 0..DATA_W-1; exit after index DATA_W-1 completes.
REQ-018 frame_done SHALL be 1 exactly on the final STOP cycle (T+44 at defaults), 0 otherwise.
REQ-019 Changes on in_data/in_valid during a frame SHALL not affect the frame in flight.
REQ-020 Back-to-back: word offered continuously SHALL be accepted at T+45, giving exactly one idle cycle (tx=1) between frames.

Reset
REQ-021 rst=1 SHALL force state IDLE, counters 0, tx=1, in_ready=1, busy=0, frame_done=0 on the next edge.
REQ-022 rst asserted mid-frame SHALL abort the frame; no partial frame resumes; a handshake coinciding with rst SHALL be dropped.

Configuration
REQ-023 Macro ODD_PARITY_TX_INJECT_EN defined: extra input inject_err (1 bit) sampled at handshake; when 1, the transmitted parity bit for that frame SHALL be inverted.
REQ-024 Macro undefined: no inject_err port; parity always per REQ-013.

Structure
REQ-025 Package odd_parity_tx_pkg SHALL hold the state enum (IDLE, START, DATA, PARITY, STOP) and constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
REQ-026 One sub-module odd_parity_tx_baud: CLKS_PER_BIT cycle counter with clear input and bit_end pulse output; FSM, shift register and parity logic stay in odd_parity_tx.

Verification
REQ-027 Reset: hold rst 3 cycles with in_valid=1 -> tx=1, in_ready=1, busy=0, frame_done=0, no frame started.
REQ-028 in_data=8'h00 at T -> tx: 0 (T+1..4), eight 0 bits, parity 1 (T+37..40), stop 1, frame_done at T+44, in_ready=1 at T+45.
REQ-029 in_data=8'h07 -> data bits 1,1,1,0,0,0,0,0; parity 0; in_data=8'hFF -> parity 1.
REQ-030 Two valid words 8'hA5 then 8'h3C held back-to-back -> second accepted at T+45, tx=1 at T+45, second START T+46..T+49, parity bits 1 then 1.
REQ-031 rst pulsed at T+20 of an 8'h55 frame -> tx=1, in_ready=1 next cycle; new word 8'h01 afterwards -> full frame with parity 0.
REQ-032 ODD_PARITY_TX_INJECT_EN with inject_err=1 and 8'h00 -> parity bit 0; CLKS_PER_BIT=1 build -> 11-cycle frame, frame_done at T+11.
